// File: rtl/mcpu5_host.sv
// mcpu5_host: host controller for a tiny CPU whose instruction memory sits on this side.
//
// The host steps the CPU through a clock/reset sequence, serves each instruction fetch
// from a 256 x 6 program memory (write port exposed to the system) and captures the
// accumulator whenever the CPU executes OUT (6'b111001), handing it to a consumer over
// a valid/ready pair. Consumer backpressure stalls the CPU clock instead of losing data.
//
// Ports:
//   clk, rst                      system clock, synchronous active-high reset
//   run                           1 = let the CPU run, 0 = pause at the next LO boundary
//   prog_we/prog_addr/prog_data   program-memory write port
//   cpu_clk, cpu_rst, cpu_inst    registered drive to the CPU
//   cpu_bus                       PC while cpu_clk=1, accumulator while cpu_clk=0
//   out_data/out_valid/out_ready  captured OUT values to the consumer
//   icount                        instruction edges issued (entries to HI), wraps
//   halted                        1 in IDLE or PAUSE
//
// Optional feature: define MCPU5_HOST_BKPT_EN to add bkpt_en/bkpt_addr/bkpt_hit, a
// single PC breakpoint that lets the current instruction finish and then pauses.
module mcpu5_host (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        prog_we,
  input  logic [7:0]  prog_addr,
  input  logic [5:0]  prog_data,
  output logic        cpu_clk,
  output logic        cpu_rst,
  output logic [5:0]  cpu_inst,
  input  logic [7:0]  cpu_bus,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] icount,
  output logic        halted
`ifdef MCPU5_HOST_BKPT_EN
  ,
  input  logic        bkpt_en,
  input  logic [7:0]  bkpt_addr,
  output logic        bkpt_hit
`endif
);

  localparam logic [5:0] OpOut = 6'b111001;

  typedef enum logic [2:0] {StIdle, StRhi, StHi, StLo, StStall, StPause} state_e;

  state_e      r_state;
  state_e      w_state_d;
  state_e      w_lo_exit;
  logic [5:0]  r_mem [256];
  logic        r_cpu_clk;
  logic        r_cpu_rst;
  logic        r_halted;
  logic [5:0]  r_cpu_inst;
  logic [7:0]  r_out_data;
  logic        r_out_valid;
  logic [15:0] r_icount;
  logic [5:0]  w_fetch;
  logic        w_is_out;
  logic        w_blocked;
  logic        w_hs;
  logic        w_capture;
  logic        w_bkpt_pend;

  // Program memory: no reset so contents survive rst. The read is combinational off the
  // current PC, so a write to the same address on the fetch edge returns the old word.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  assign w_fetch   = r_mem[cpu_bus];
  assign w_is_out  = (r_cpu_inst == OpOut);
  assign w_blocked = r_out_valid && !out_ready;
  assign w_hs      = r_out_valid && out_ready;

  // LO captures unless the previous value is still unconsumed; STALL retries each cycle.
  assign w_capture = ((r_state == StLo) && w_is_out && !w_blocked) ||
                     ((r_state == StStall) && out_ready);

`ifdef MCPU5_HOST_BKPT_EN
  logic r_bkpt_hit;

  // Dropping run is the only way to acknowledge a hit, so clearing takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bkpt_hit <= 1'b0;
    end else if (!run) begin
      r_bkpt_hit <= 1'b0;
    end else if ((r_state == StHi) && bkpt_en && (cpu_bus == bkpt_addr)) begin
      r_bkpt_hit <= 1'b1;
    end
  end

  assign w_bkpt_pend = r_bkpt_hit;
  assign bkpt_hit    = r_bkpt_hit;
`else
  assign w_bkpt_pend = 1'b0;
`endif

  assign w_lo_exit = (!run || w_bkpt_pend) ? StPause : StHi;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:      w_state_d = run ? StRhi : StIdle;
      StRhi, StHi: w_state_d = StLo;
      StLo:        w_state_d = (w_is_out && w_blocked) ? StStall : w_lo_exit;
      StStall:     w_state_d = out_ready ? w_lo_exit : StStall;
      StPause:     w_state_d = (run && !w_bkpt_pend) ? StHi : StPause;
      default:     w_state_d = StIdle;
    endcase
  end

  // State plus all CPU-facing outputs, registered from the next state so they change
  // together with the state on the same clk edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cpu_clk   <= 1'b0;
      r_cpu_rst   <= 1'b1;
      r_halted    <= 1'b1;
      r_cpu_inst  <= 6'd0;
      r_out_data  <= 8'd0;
      r_out_valid <= 1'b0;
      r_icount    <= 16'd0;
    end else begin
      r_state   <= w_state_d;
      r_cpu_clk <= (w_state_d == StRhi) || (w_state_d == StHi);
      r_cpu_rst <= (w_state_d == StIdle) || (w_state_d == StRhi);
      r_halted  <= (w_state_d == StIdle) || (w_state_d == StPause);
      if ((r_state == StRhi) || (r_state == StHi)) begin
        r_cpu_inst <= w_fetch;
      end
      if (w_state_d == StHi) begin
        r_icount <= r_icount + 16'd1;
      end
      // A capture on the handshake edge refills the slot, so valid stays high.
      if (w_capture) begin
        r_out_data  <= cpu_bus;
        r_out_valid <= 1'b1;
      end else if (w_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign cpu_clk   = r_cpu_clk;
  assign cpu_rst   = r_cpu_rst;
  assign cpu_inst  = r_cpu_inst;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign icount    = r_icount;
  assign halted    = r_halted;

endmodule

// File: tb/tb_mcpu5_host.sv
// Bench for mcpu5_host. A toy CPU hangs off the host (ISA: 00xxxx jump to 0,
// 01xxxx acc=imm, 10xxxx acc+=imm, 11xxxx no-op, OUT=111001 also a no-op to the CPU).
// An instruction-level interpreter of the loaded program fills the expected fetch and
// OUT queues; a monitor pops them on every LO entry and every out handshake.
module tb_mcpu5_host;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = 8'd0;
  logic [5:0]  prog_data = 6'd0;
  logic        cpu_clk;
  logic        cpu_rst;
  logic [5:0]  cpu_inst;
  logic [7:0]  cpu_bus;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] icount;
  logic        halted;
`ifdef MCPU5_HOST_BKPT_EN
  logic        bkpt_en = 1'b0;
  logic [7:0]  bkpt_addr = 8'd0;
  logic        bkpt_hit;
`endif

  always #5 clk = ~clk;

  mcpu5_host u_dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .cpu_inst  (cpu_inst),
    .cpu_bus   (cpu_bus),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .icount    (icount),
    .halted    (halted)
`ifdef MCPU5_HOST_BKPT_EN
    ,
    .bkpt_en   (bkpt_en),
    .bkpt_addr (bkpt_addr),
    .bkpt_hit  (bkpt_hit)
`endif
  );

  // Toy CPU: executes the presented instruction on each rising cpu_clk.
  logic [7:0] c_pc = 8'd0;
  logic [7:0] c_acc = 8'd0;
  assign cpu_bus = cpu_clk ? c_pc : c_acc;

  always @(posedge cpu_clk) begin
    if (cpu_rst) begin
      c_pc  <= 8'd0;
      c_acc <= 8'd0;
    end else begin
      case (cpu_inst[5:4])
        2'b00: c_pc <= 8'd0;
        2'b01: begin c_acc <= {4'd0, cpu_inst[3:0]}; c_pc <= c_pc + 8'd1; end
        2'b10: begin c_acc <= c_acc + {4'd0, cpu_inst[3:0]}; c_pc <= c_pc + 8'd1; end
        default: c_pc <= c_pc + 8'd1;
      endcase
    end
  end

  logic [5:0] prog [256];
  logic [5:0] exp_inst [$];
  logic [7:0] exp_out [$];
  int  checks = 0;
  int  failures = 0;
  bit  mon_en = 1'b0;
  bit  prev_clk = 1'b0;
  int  n_fetch = 0;
  int  n_out = 0;
  bit  rand_run = 1'b0;
  bit  rand_ready = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: each LO entry presents one fetched instruction; icount must equal the number
  // of fetches before this one. Each handshake consumes one expected OUT value.
  always @(negedge clk) begin
    if (!mon_en) begin
      n_fetch <= 0;
      n_out   <= 0;
    end else begin
      if (prev_clk && !cpu_clk) begin
        if (exp_inst.size() == 0) begin
          check("fetch_underflow", 1, 0);
        end else begin
          check("fetch_inst", cpu_inst, exp_inst.pop_front());
        end
        check("icount_at_lo", icount, n_fetch);
        n_fetch <= n_fetch + 1;
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) begin
          check("out_underflow", 1, 0);
        end else begin
          check("out_data", out_data, exp_out.pop_front());
        end
        n_out <= n_out + 1;
      end
    end
    prev_clk <= cpu_clk;
  end

  // Instruction-level interpretation of prog[]: fetch order and OUT values only.
  task automatic build_expect(input int n);
    logic [7:0] pc;
    logic [7:0] acc;
    logic [5:0] ins;
    pc  = 8'd0;
    acc = 8'd0;
    for (int i = 0; i < n; i++) begin
      ins = prog[pc];
      exp_inst.push_back(ins);
      if (ins == 6'h39) exp_out.push_back(acc);
      case (ins[5:4])
        2'b00: pc = 8'd0;
        2'b01: begin acc = {4'd0, ins[3:0]}; pc = pc + 8'd1; end
        2'b10: begin acc = acc + {4'd0, ins[3:0]}; pc = pc + 8'd1; end
        default: pc = pc + 8'd1;
      endcase
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (rand_run) run = ($urandom_range(0, 9) != 0);
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic load_prog(input int len);
    for (int i = 0; i < len; i++) begin
      prog_we   = 1'b1;
      prog_addr = i[7:0];
      prog_data = prog[i];
      @(posedge clk);
      #1;
    end
    prog_we = 1'b0;
  endtask

  task automatic start_scenario(input int len);
    mon_en = 1'b0;
    run    = 1'b0;
    rst    = 1'b1;
    load_prog(len);
    exp_inst.delete();
    exp_out.delete();
    build_expect(600);
    step(2);
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic set_loop_prog();
    prog[0] = 6'h15;
    prog[1] = 6'h39;
    prog[2] = 6'h0E;
  endtask

  // Waits (bounded) for a HI cycle, optionally with a specific PC on the bus.
  task automatic wait_hi(input bit any_pc, input logic [7:0] pc, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      at_neg();
      if (cpu_clk && !cpu_rst && (any_pc || cpu_bus == pc)) ok = 1'b1;
    end
    check(name, ok, 1);
  endtask

  initial begin
    int len;
    logic [3:0] imm;

    // Reset held for two cycles.
    rst = 1'b1;
    step(2);
    at_neg();
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_cpu_clk", cpu_clk, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_cpu_inst", cpu_inst, 0);
    check("rst_icount", icount, 0);
    check("rst_halted", halted, 1);

    // OUT loop with a ready consumer.
    set_loop_prog();
    start_scenario(3);
    out_ready = 1'b1;
    run = 1'b1;
    step(60);
    at_neg();
    check("loop_out_progress", (n_out >= 7), 1);

    // Backpressure: second OUT must stall the CPU with the first value held.
    start_scenario(3);
    out_ready = 1'b0;
    run = 1'b1;
    step(20);
    at_neg();
    check("stall_cpu_clk", cpu_clk, 0);
    check("stall_halted", halted, 0);
    check("stall_valid", out_valid, 1);
    check("stall_data", out_data, 8'h05);
    check("stall_icount", icount, 4);
    step(3);
    at_neg();
    check("stall_icount_hold", icount, 4);
    check("stall_cpu_clk_hold", cpu_clk, 0);
    out_ready = 1'b1;
    step(40);
    at_neg();
    check("stall_drain", (n_out >= 3), 1);

    // Pause from HI, then resume without an icount gap.
    start_scenario(3);
    out_ready = 1'b1;
    run = 1'b1;
    step(11);
    wait_hi(1'b1, 8'd0, "pause_hi_seen");
    run = 1'b0;
    @(posedge clk);
    @(posedge clk);
    at_neg();
    check("pause_halted", halted, 1);
    check("pause_cpu_clk", cpu_clk, 0);
    check("pause_icount", icount, n_fetch - 1);
    step(3);
    at_neg();
    check("pause_hold_clk", cpu_clk, 0);
    check("pause_hold_icount", icount, n_fetch - 1);
    run = 1'b1;
    at_neg();
    check("resume_cpu_clk", cpu_clk, 1);
    check("resume_halted", halted, 0);
    check("resume_icount", icount, n_fetch);
    step(20);

    // Write collision on the fetch edge of pc=1.
    start_scenario(3);
    mon_en = 1'b0;
    out_ready = 1'b1;
    run = 1'b1;
    wait_hi(1'b0, 8'd1, "collide_hi_pc1");
    prog_we   = 1'b1;
    prog_addr = 8'h01;
    prog_data = 6'h2A;
    @(posedge clk);
    #1;
    prog_we = 1'b0;
    at_neg();
    check("collide_old", cpu_inst, 6'h39);
    wait_hi(1'b0, 8'd1, "collide_hi_pc1_again");
    at_neg();
    check("collide_new", cpu_inst, 6'h2A);

`ifdef MCPU5_HOST_BKPT_EN
    // Breakpoint at pc 2, acknowledged by dropping run.
    set_loop_prog();
    start_scenario(3);
    bkpt_en   = 1'b1;
    bkpt_addr = 8'h02;
    out_ready = 1'b1;
    run = 1'b1;
    step(2);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        at_neg();
        if (halted) seen = 1'b1;
      end
      check("bkpt_pause_seen", seen, 1);
    end
    check("bkpt_hit_set", bkpt_hit, 1);
    check("bkpt_icount", icount, 2);
    step(3);
    at_neg();
    check("bkpt_hold", halted, 1);
    run = 1'b0;
    at_neg();
    check("bkpt_cleared", bkpt_hit, 0);
    check("bkpt_still_halted", halted, 1);
    run = 1'b1;
    at_neg();
    check("bkpt_resume_clk", cpu_clk, 1);
    check("bkpt_resume_pc", cpu_bus, 0);
    bkpt_en = 1'b0;
`endif

    // Randomized programs with random run and consumer backpressure.
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(3, 12);
      for (int i = 0; i < len - 1; i++) begin
        imm = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 3))
          0: prog[i] = {2'b01, imm};
          1: prog[i] = {2'b10, imm};
          2: prog[i] = 6'h39;
          default: prog[i] = 6'h30;
        endcase
      end
      prog[len - 1] = {2'b00, 4'($urandom_range(0, 15))};
      prog[$urandom_range(0, len - 2)] = 6'h39;
      start_scenario(len);
      run = 1'b1;
      rand_run = 1'b1;
      rand_ready = 1'b1;
      step(400);
      rand_run = 1'b0;
      rand_ready = 1'b0;
      at_neg();
      check("rand_fetch_progress", (n_fetch >= 40), 1);
      check("rand_out_progress", (n_out >= 1), 1);
    end

    // Reset mid-operation.
    mon_en = 1'b0;
    run = 1'b1;
    out_ready = 1'b0;
    step(7);
    rst = 1'b1;
    @(posedge clk);
    at_neg();
    check("midrst_cpu_clk", cpu_clk, 0);
    check("midrst_cpu_rst", cpu_rst, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_cpu_inst", cpu_inst, 0);
    check("midrst_icount", icount, 0);
    check("midrst_halted", halted, 1);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcpu5_host.md
MCPU5_HOST -- requirements
Module: mcpu5_host

Interface
REQ-001 The module SHALL have no parameters; program memory SHALL be fixed at 256 x 6 bits.
REQ-002 clk  in  1  system clock; all state SHALL change on its rising edge only.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 run  in  1  1 = CPU clocking enabled; 0 = pause at the next cycle boundary.
REQ-005 prog_we  in  1  program-memory write strobe.
REQ-006 prog_addr  in  8  program-memory write address.
REQ-007 prog_data  in  6  program-memory write data.
REQ-008 cpu_clk  out  1  registered CPU clock.
REQ-009 cpu_rst  out  1  registered CPU reset.
REQ-010 cpu_inst  out  6  registered instruction driven to the CPU.
REQ-011 cpu_bus  in  8  CPU multiplexed bus: PC while cpu_clk=1, accumulator while cpu_clk=0.
REQ-012 out_data  out  8  accumulator value captured by an OUT instruction.
REQ-013 out_valid  out  1  out_data holds an unconsumed value.
REQ-014 out_ready  in  1  consumer accepts out_data when out_valid=1 and out_ready=1 on the same clk edge.
REQ-015 icount  out  16  count of CPU instruction edges issued.
REQ-016 halted  out  1  1 in IDLE or PAUSE.

Function
REQ-017 The FSM SHALL have states IDLE, RHI, HI, LO, STALL and PAUSE; every state SHALL last at least one clk cycle.
REQ-018 Output encoding per state SHALL be as follows: cpu_clk=1 in RHI and HI, 0 in all others; cpu_rst=1 in IDLE and RHI, 0 in all others.
REQ-019 IDLE SHALL move to RHI when run=1.
REQ-020 RHI SHALL move to LO.
REQ-021 HI SHALL move to LO.
REQ-022 On leaving RHI or HI, cpu_inst SHALL load prog_mem[cpu_bus] (the PC value sampled in that state).
REQ-023 In LO, if cpu_inst=6'b111001 (OUT), out_data SHALL load cpu_bus and out_valid SHALL set at the end of LO.
REQ-024 LO SHALL move to STALL if it captured an OUT while out_valid=1 and out_ready=0 (previous value unconsumed); out_data SHALL NOT be overwritten in that case.
REQ-025 STALL SHALL perform the capture of REQ-023 and exit as LO would once out_ready=1.
REQ-026 LO SHALL otherwise move to PAUSE if run=0 (or the breakpoint is hit), else to HI.
REQ-027 PAUSE SHALL move to HI when run=1 and no breakpoint is pending; cpu_inst SHALL hold in PAUSE.
REQ-028 A handshake (out_valid & out_ready) SHALL clear out_valid unless a capture occurs on the same edge, in which case out_valid SHALL stay 1 with the new data.
REQ-029 icount SHALL increment by 1, wrapping at 16'hFFFF, on each entry to HI.
REQ-030 A prog_write SHALL take effect on the next edge; a fetch from the address being written on the same edge SHALL return the old data.
REQ-031 The minimum CPU instruction period SHALL be 2 clk cycles (HI + LO).

Reset
REQ-032 While rst=1 the block SHALL enter IDLE and drive cpu_clk=0, cpu_rst=1, cpu_inst=0, out_data=0, out_valid=0, icount=0 and halted=1.
REQ-033 Program memory contents SHALL be preserved across rst.
REQ-034 An rst asserted mid-operation (any state) SHALL abort the cycle immediately with the values of REQ-032.

Configuration
REQ-035 With MCPU5_HOST_BKPT_EN defined, the module SHALL add ports bkpt_en (in 1), bkpt_addr (in 8) and bkpt_hit (out 1, reset 0).
REQ-036 With MCPU5_HOST_BKPT_EN defined, bkpt_hit SHALL set in HI when bkpt_en=1 and cpu_bus=bkpt_addr; the fetch and LO SHALL complete normally, then the FSM SHALL enter PAUSE.
REQ-037 With MCPU5_HOST_BKPT_EN defined, bkpt_hit SHALL clear when run=0, and resume SHALL require run=1 with bkpt_hit=0.
REQ-038 Without MCPU5_HOST_BKPT_EN defined, the bkpt ports and logic SHALL be absent and the FSM SHALL behave as with bkpt_en=0.

Verification
REQ-039 Reset scenario: rst=1 for 2 cycles -> IDLE, cpu_rst=1, cpu_clk=0, out_valid=0, icount=0, halted=1.
REQ-040 OUT loop scenario: prog 0x15, 0x39, 0x0E at addresses 0..2 with run=1 and out_ready=1 -> out_data=8'h05 with out_valid pulses, pc sequence 0,1,2,0, icount +3 per loop.
REQ-041 Backpressure scenario: same program with out_ready=0 -> first 8'h05 held, second OUT enters STALL with cpu_clk=0 held; out_ready=1 -> exactly one further capture, no data lost.
REQ-042 Pause scenario: run=0 in HI -> LO completes then PAUSE with halted=1 and cpu_clk=0; run=1 -> HI, icount continues without a gap.
REQ-043 Write-collision scenario: prog_we at address 8'h01 on the fetch edge of pc=1 -> old instruction fetched; new instruction fetched on the next loop.
REQ-044 Breakpoint scenario (MCPU5_HOST_BKPT_EN): bkpt_addr=8'h02 -> bkpt_hit=1 and PAUSE after pc=2; run 1->0->1 -> execution resumes at pc 0.
